serial_full_adder: RTL and testbench
====================================

# serial_full_adder

Parametrised bit-serial adder/subtractor that drives one full-adder cell over WIDTH operand bits, one bit per clock, LSB first. It is the sequential successor to the single-bit full-adder cell. It adds a start/busy/done handshake, a subtract mode, carry-in, carry-out and signed overflow. It trades throughput for area wherever multi-bit add/subtract is needed at low rate.

## Interface
- WIDTH, 8, operand and result width in bits; legal range WIDTH >= 2.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only while the block is not busy.
- sub  input  1  mode, sampled with start: 0 = a + b + cin, 1 = a - b (cin ignored).
- cin  input  1  carry-in for add mode.
- a  input  WIDTH  operand A, sampled with start.
- b  input  WIDTH  operand B, sampled with start.
- busy  output  1  high while bits are being processed.
- done  output  1  one-cycle pulse; result outputs are valid from this cycle onward.
- sum  output  WIDTH  result, registered.
- cout  output  1  final carry out; in sub mode, 1 = no borrow (a >= b unsigned).
- ovf  output  1  two's-complement overflow: carry into MSB XOR carry out of MSB.

## Operation
- Clock is clk. Reset is synchronous, active-high on rst.
- States:
  - IDLE: busy=0, done=0.
  - RUN: busy=1.
  - DONE: busy=0, done=1, lasts exactly one cycle.
- Transitions:
  - IDLE -> RUN on start=1.
  - RUN -> DONE after WIDTH bit cycles.
  - DONE -> RUN if start=1, else DONE -> IDLE.
- Start is accepted in IDLE and DONE only. While in RUN, start, a, b, sub and cin are ignored.
- On accept:
  - A shift register loads a.
  - B shift register loads b, or ~b when sub=1.
  - Carry register loads cin, or 1 when sub=1.
  - Bit counter clears to 0.
  - Result shift register clears.
- Each RUN cycle:
  - Full adder combines A[0], B[0] and carry.
  - The sum bit shifts into the result MSB; A and B shift right.
  - Carry register takes the cell's carry.
  - Counter increments.
  - On the bit WIDTH-1 cycle, the carry-in of that bit is captured for ovf.
- Arithmetic is modulo 2^WIDTH. cout and ovf follow standard two's-complement add rules applied to a + (sub ? ~b : b) + (sub ? 1 : cin).
- sum, cout and ovf update only on the transition into DONE. They hold their last value through IDLE and any following RUN until the next completion.
- rst=1 at any cycle, including mid-RUN:
  - Aborts the operation and enters IDLE.
  - Clears busy, done, sum, cout, ovf, the counter and all shift/carry registers to 0.
  - No partial result is ever presented.

## Timing
- All outputs are registered. Reset value of every output is 0.
- Start sampled at edge E0 -> busy=1 after E0.
- Bits 0..WIDTH-1 are processed at edges E1..EWIDTH.
- After EWIDTH: busy=0, done=1, results valid. Latency from start edge to done is WIDTH cycles.
- After EWIDTH+1: done=0, unless start was accepted at EWIDTH+1, in which case busy=1.
- Back-to-back throughput: one result per WIDTH+1 cycles.
- start and rst in the same cycle: rst wins.

## Test plan
- Reset: assert rst 2 cycles with start=1 -> busy=done=sum=cout=ovf=0, state IDLE. Next start with a=8'h01, b=8'h01 gives sum=8'h02 after 8 cycles.
- WIDTH=8 add: a=8'h5A, b=8'h3C, cin=0, sub=0 -> done exactly 8 cycles after start edge with sum=8'h96, cout=0, ovf=1. busy high for exactly 8 cycles.
- Add with carry-in: a=8'hFF, b=8'h01, cin=1 -> sum=8'h01, cout=1, ovf=0. Back-to-back start during the DONE cycle with a=8'h7F, b=8'h01, cin=0 -> sum=8'h80, cout=0, ovf=1, 9 cycles after the first done.
- Subtract: a=8'h10, b=8'h20, sub=1 -> sum=8'hF0, cout=0, ovf=0. Then a=8'h80, b=8'h01, sub=1 -> sum=8'h7F, cout=1, ovf=1.
- Robustness: pulse start with new operands at bit 3 of a RUN -> ignored, result matches the original operands. rst at bit 4 of a RUN -> all outputs 0 next cycle, no done pulse. The following start completes correctly.
- Exhaustive: WIDTH=3, all a, b, cin, sub combinations (256 operations) -> sum, cout and ovf match a behavioural model. Each done is a single-cycle pulse exactly 3 cycles after its start.

Source files
------------

// File: rtl/serial_full_adder_if.sv
// serial_full_adder_if: request operands and registered result/handshake of the bit-serial adder
interface serial_full_adder_if #(parameter int WIDTH = 8);
  logic start;
  logic sub;
  logic cin;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic busy;
  logic done;
  logic [WIDTH-1:0] sum;
  logic cout;
  logic ovf;
  modport master (output start, sub, cin, a, b, input busy, done, sum, cout, ovf);
  modport slave (input start, sub, cin, a, b, output busy, done, sum, cout, ovf);
endinterface

// File: rtl/serial_full_adder.sv
// serial_full_adder: one full-adder cell stepped over WIDTH bits LSB first, with add/sub, carry and overflow
module serial_full_adder #(
  parameter int WIDTH = 8
) (
  input logic clk,
  input logic rst,
  serial_full_adder_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [WIDTH-1:0] sa, sb;
  logic [WIDTH-2:0] res;
  logic [CW-1:0] cnt;
  logic carry, s_bit, c_bit;
  logic [WIDTH-1:0] res_next;
  assign s_bit = sa[0] ^ sb[0] ^ carry;
  assign c_bit = (sa[0] & sb[0]) | (carry & (sa[0] ^ sb[0]));
  assign res_next = {s_bit, res};
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sa <= '0;
      sb <= '0;
      res <= '0;
      cnt <= '0;
      carry <= 1'b0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.sum <= '0;
      bus.cout <= 1'b0;
      bus.ovf <= 1'b0;
    end else if (state != RUN && bus.start) begin
      state <= RUN;
      sa <= bus.a;
      sb <= bus.sub ? ~bus.b : bus.b;
      carry <= bus.sub | bus.cin;
      res <= '0;
      cnt <= '0;
      bus.busy <= 1'b1;
      bus.done <= 1'b0;
    end else if (state == RUN) begin
      sa <= sa >> 1;
      sb <= sb >> 1;
      carry <= c_bit;
      res <= res_next[WIDTH-1:1];
      cnt <= cnt + 1'b1;
      // carry still holds the carry into the MSB on the last bit
      if (cnt == LAST) begin
        state <= DONE;
        bus.busy <= 1'b0;
        bus.done <= 1'b1;
        bus.sum <= res_next;
        bus.cout <= c_bit;
        bus.ovf <= carry ^ c_bit;
      end
    end else begin
      state <= IDLE;
      bus.done <= 1'b0;
    end
  end
endmodule

// File: tb/tb_serial_full_adder.sv
// tb_serial_full_adder: directed WIDTH=8 checks plus exhaustive WIDTH=3 sweep against a behavioural model
module tb_serial_full_adder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_tests = 0;
  int n_fail = 0;
  serial_full_adder_if #(.WIDTH(8)) bus8 ();
  serial_full_adder_if #(.WIDTH(3)) bus3 ();
  serial_full_adder #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8.slave));
  serial_full_adder #(.WIDTH(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3.slave));
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b, input logic ci,
                     input logic sb, input logic [7:0] es, input logic eco, input logic eov);
    int lat, nbusy;
    bus8.a = a;
    bus8.b = b;
    bus8.cin = ci;
    bus8.sub = sb;
    bus8.start = 1'b1;
    @(negedge clk);
    bus8.start = 1'b0;
    lat = 0;
    nbusy = 0;
    while (!bus8.done && lat < 20) begin
      nbusy += int'(bus8.busy);
      @(negedge clk);
      lat++;
    end
    check({tag, "_lat"}, lat, 8);
    check({tag, "_busy"}, nbusy, 8);
    check({tag, "_sum"}, bus8.sum, es);
    check({tag, "_cout"}, bus8.cout, eco);
    check({tag, "_ovf"}, bus8.ovf, eov);
  endtask

  initial begin
    bus8.start = 1'b1;
    bus8.a = 8'hAA;
    bus8.b = 8'h55;
    bus8.sub = 1'b0;
    bus8.cin = 1'b1;
    bus3.start = 1'b0;
    bus3.a = '0;
    bus3.b = '0;
    bus3.sub = 1'b0;
    bus3.cin = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", bus8.busy, 0);
    check("rst_done", bus8.done, 0);
    check("rst_sum", bus8.sum, 0);
    check("rst_cout", bus8.cout, 0);
    check("rst_ovf", bus8.ovf, 0);
    rst = 1'b0;
    op8("inc", 8'h01, 8'h01, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0);
    @(negedge clk);
    check("done_pulse", bus8.done, 0);
    op8("add", 8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1);
    @(negedge clk);
    op8("addc", 8'hFF, 8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0);
    op8("b2b", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
    @(negedge clk);
    op8("sub1", 8'h10, 8'h20, 1'b0, 1'b1, 8'hF0, 1'b0, 1'b0);
    @(negedge clk);
    op8("sub2", 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);
    @(negedge clk);
    // start pulsed mid-run with different operands must be ignored
    fork
      op8("ign", 8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 1'b0);
      begin
        repeat (4) @(negedge clk);
        bus8.a = 8'hFF;
        bus8.b = 8'hFF;
        bus8.sub = 1'b1;
        bus8.start = 1'b1;
        @(negedge clk);
        bus8.start = 1'b0;
      end
    join
    @(negedge clk);
    // reset mid-run aborts without any done pulse
    bus8.a = 8'h5A;
    bus8.b = 8'h3C;
    bus8.sub = 1'b0;
    bus8.cin = 1'b0;
    bus8.start = 1'b1;
    @(negedge clk);
    bus8.start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy", bus8.busy, 0);
    check("abort_done", bus8.done, 0);
    check("abort_sum", bus8.sum, 0);
    check("abort_cout", bus8.cout, 0);
    check("abort_ovf", bus8.ovf, 0);
    rst = 1'b0;
    begin
      int seen = 0;
      repeat (12) begin
        @(negedge clk);
        seen += int'(bus8.done);
      end
      check("abort_nodone", seen, 0);
    end
    op8("after", 8'h01, 8'hFE, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0);
    @(negedge clk);
    for (int i = 0; i < 256; i++) begin
      logic [2:0] a, b, bv, es;
      logic ci, sb, eco, eov;
      logic [3:0] t;
      int lat;
      a = i[2:0];
      b = i[5:3];
      ci = i[6];
      sb = i[7];
      bv = sb ? ~b : b;
      t = {1'b0, a} + {1'b0, bv} + {3'b0, sb | ci};
      es = t[2:0];
      eco = t[3];
      eov = (a[2] == bv[2]) && (es[2] != a[2]);
      bus3.a = a;
      bus3.b = b;
      bus3.cin = ci;
      bus3.sub = sb;
      bus3.start = 1'b1;
      @(negedge clk);
      bus3.start = 1'b0;
      lat = 0;
      while (!bus3.done && lat < 10) begin
        @(negedge clk);
        lat++;
      end
      check($sformatf("w3_lat_%0d", i), lat, 3);
      check($sformatf("w3_sum_%0d", i), bus3.sum, es);
      check($sformatf("w3_cout_%0d", i), bus3.cout, eco);
      check($sformatf("w3_ovf_%0d", i), bus3.ovf, eov);
      @(negedge clk);
      check($sformatf("w3_pulse_%0d", i), bus3.done, 0);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
